vmu_add_seq: RTL and testbench
==============================

# vmu_add_seq

Command sequencer for the VMU adder stage (`adder`). It accepts reduce and subtract commands and streams 8-lane input beats into the adder. In reduce mode it accumulates the per-beat 8-input sums into a wide dot-product result. In subtract mode it drives mode 1 and returns the adder's registered 4-lane difference vectors with valid/last framing. It sits between the VMU multiplier array and the OMP correlation/residual-update logic, and is the only block that drives the adder's `mode` and data inputs.

## Interface

Parameters:
- `DATA_W`, default 16 (`VMU_DATA_WIDTH`): lane width; must match the adder.
- `LEN_W`, default 8: width of the beat-count field.
- `ACC_W`, default 24 (`DATA_W+LEN_W`): reduce accumulator width.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset. The top level drives the adder's active-high reset with `~rst`.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  1  0 = reduce, 1 = subtract.
- `cmd_len`  in  LEN_W  number of input beats.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  high in RED/SUB while beats remain.
- `in_data`  in  8*DATA_W  lane k at `[k*DATA_W +: DATA_W]`, mapped to adder `din(k+1)`.
- `add_mode`  out  1  to adder `mode`.
- `add_din`  out  8*DATA_W  to adder `din1..din8`, same lane order as `in_data`.
- `add_dout`  in  DATA_W  from adder `dout`; combinational, same cycle.
- `add_dout_vec`  in  4*DATA_W  from adder `dout_vec`; registered, 1-cycle latency.
- `sum_valid`  out  1  one-cycle pulse; reduce result ready.
- `sum_data`  out  ACC_W  reduce result; held until the next command is accepted.
- `vec_valid`  out  1  subtract result beat.
- `vec_data`  out  4*DATA_W  lane j = `din(2j+2) - din(2j+1)`, modulo 2^DATA_W.
- `vec_last`  out  1  qualifies the final `vec_valid`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at command completion.

## Operation

States: IDLE, RED, SUB, DRAIN, DONE.

Command acceptance:
- A command is accepted on `cmd_valid && cmd_ready`.
- On acceptance: latch `cmd_len` into the beat counter and clear the accumulator.
- Next state: RED if `cmd_op=0`, SUB if `cmd_op=1`, DONE directly if `cmd_len=0`.

Beat transfer:
- A beat transfers on `in_valid && in_ready`.
- `add_din = in_data` on a transfer cycle; all-zero otherwise.
- `in_data` is ignored when not transferring.
- Each transfer decrements the beat counter.

RED state:
- `add_mode=0`.
- Per transfer: `acc <= acc + sext(add_dout)`, with `add_dout` taken as signed DATA_W and sign-extended.
- The adder's internal 16-bit wrap is preserved; the accumulator wraps modulo 2^ACC_W.
- Last transfer → DONE.

SUB state:
- `add_mode=1`.
- Per transfer: `vec_valid=1` in the following cycle with `vec_data = add_dout_vec`.
- Idle cycles (`in_valid` low) produce no `vec_valid`.
- Last transfer → DRAIN.

DRAIN state:
- `add_mode=0`.
- Emits the final vector with `vec_valid=1` and `vec_last=1`.
- → DONE.

DONE state:
- `done=1`.
- `sum_valid=1` only if the command was a reduce, including `len=0` (result 0).
- → IDLE.

General rules:
- `add_mode` is 0 in every state except SUB.
- Result outputs have no backpressure; consumers must accept `vec_valid` and `sum_valid` unconditionally.

Reset:
- Asserting `rst` low in any state forces IDLE immediately.
- Accumulator, beat counter and `sum_data` clear to 0.
- All outputs are 0 except `cmd_ready`, which is 1 in IDLE once `rst` is deasserted.
- A command interrupted by reset produces no `done` and no partial results.

## Timing

- `cmd_ready` is 1 only in IDLE, so a new command is accepted no sooner than the cycle after DONE.
- Reduce, `len=N`: `sum_valid` and `done` assert exactly 1 cycle after the N-th transfer, with `sum_data` valid in that cycle.
- Subtract, `len=N`: `vec_valid` asserts 1 cycle after each transfer. `done` asserts 2 cycles after the N-th transfer (DRAIN, then DONE).
- `len=0`: `done` asserts 1 cycle after acceptance; `in_ready` never rises.
- Zero-bubble streaming: with `in_valid` held high, reduce and subtract both sustain 1 beat/cycle.
- `in_valid` gaps stretch RED/SUB cycle-for-cycle; results are unchanged.

## Test plan

- **Reset:** hold `rst=0` for 3 cycles with random inputs, then release.
  - During reset all outputs are 0 and `add_mode=0`.
  - After release `cmd_ready=1`.
- **Reduce wrap:** reduce `len=2`; beat 1 all lanes = 1, beat 2 all lanes = 0x7FFF.
  - Beat 2's `add_dout` wraps to 0xFFF8 (-8), giving `sum_data=0`.
  - `sum_valid` and `done` pulse 1 cycle after beat 2.
- **Subtract with gaps:** subtract `len=3` with one idle cycle between beats; beat 1 lanes (din1..din8) = 5, 12, 1, 1, -2, 3, 7, 0.
  - First vector = {-7, 5, 0, 7}, listed as lanes 3..0.
  - `vec_valid` asserts 1 cycle after each transfer only; `vec_last` asserts on the 3rd; `done` follows 1 cycle later.
- **Subtract edge values:** din1=0, din2=-3 → lane0 = -3. din3=-32768, din4=0 → lane1 = -32768 (0x8000).
- **Zero length:** reduce `len=0` → `in_ready` stays 0; `done=1` and `sum_valid=1` with `sum_data=0` 1 cycle after acceptance.
- **Reset mid-command:** assert reset after 1 of 4 reduce beats.
  - Immediately: `busy=0`, no `done`, `sum_data=0`.
  - A following reduce `len=1` with all lanes = 2 returns `sum_data=16`.

Source files
------------

// File: rtl/vmu_add_seq.sv
// vmu_add_seq: command sequencer feeding the VMU adder (reduce / subtract).
// Ports: cmd_* command, in_* beat stream, add_* adder side, sum_*/vec_* results.
module vmu_add_seq #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = DATA_W + LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic                  add_mode,
  output logic [8*DATA_W-1:0]   add_din,
  input  logic [DATA_W-1:0]     add_dout,
  input  logic [4*DATA_W-1:0]   add_dout_vec,
  output logic                  sum_valid,
  output logic [ACC_W-1:0]      sum_data,
  output logic                  vec_valid,
  output logic [4*DATA_W-1:0]   vec_data,
  output logic                  vec_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_SUB,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic               done_q;
  logic               sumv_q;
  logic               vecv_q;
  logic               vlast_q;
  logic               accept;
  logic               xfer;
  logic               last;
  logic [ACC_W-1:0]   dout_ext;

  // rst gates cmd_ready so it reads 0 while reset is held
  assign cmd_ready = rst && (state == S_IDLE);
  assign in_ready  = ((state == S_RED) || (state == S_SUB))
                     && (cnt != '0);
  assign accept    = cmd_valid && cmd_ready;
  assign xfer      = in_valid && in_ready;
  assign last      = xfer && (cnt == LEN_W'(1));
  assign add_mode  = (state == S_SUB);
  assign add_din   = xfer ? in_data : '0;
  assign dout_ext  = {{(ACC_W-DATA_W){add_dout[DATA_W-1]}},
                      add_dout};

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign sum_valid = sumv_q;
  assign sum_data  = acc;
  assign vec_valid = vecv_q;
  assign vec_last  = vlast_q;
  // adder vector is registered; pass it only when framed
  assign vec_data  = vecv_q ? add_dout_vec : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      done_q  <= 1'b0;
      sumv_q  <= 1'b0;
      vecv_q  <= 1'b0;
      vlast_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      sumv_q  <= 1'b0;
      vecv_q  <= 1'b0;
      vlast_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= cmd_len;
            acc <= '0;
            if (cmd_len == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              sumv_q <= ~cmd_op;
            end else begin
              state <= cmd_op ? S_SUB : S_RED;
            end
          end
        end
        S_RED: begin
          if (xfer) begin
            acc <= acc + dout_ext;
            cnt <= cnt - LEN_W'(1);
            if (last) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              sumv_q <= 1'b1;
            end
          end
        end
        S_SUB: begin
          if (xfer) begin
            cnt    <= cnt - LEN_W'(1);
            vecv_q <= 1'b1;
            if (last) begin
              state   <= S_DRAIN;
              vlast_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmu_add_seq.sv
// tb_vmu_add_seq: randomized self-checking bench for vmu_add_seq.
// Includes a behavioural adder and a transaction-level result model.
module tb_vmu_add_seq;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_op = 1'b0;
  logic [LW-1:0]   cmd_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*DW-1:0] in_data = '0;
  logic            add_mode;
  logic [8*DW-1:0] add_din;
  logic [DW-1:0]   add_dout;
  logic [4*DW-1:0] add_dout_vec;
  logic [4*DW-1:0] diff_c;
  logic            sum_valid;
  logic [AW-1:0]   sum_data;
  logic            vec_valid;
  logic [4*DW-1:0] vec_data;
  logic            vec_last;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;
  int gap_mode = 0;
  logic [8*DW-1:0] beat_q[$];

  always #5 clk = ~clk;

  vmu_add_seq #(.DATA_W(DW), .LEN_W(LW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_mode(add_mode), .add_din(add_din),
    .add_dout(add_dout), .add_dout_vec(add_dout_vec),
    .sum_valid(sum_valid), .sum_data(sum_data),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last),
    .busy(busy), .done(done)
  );

  // behavioural adder: combinational 8-input sum, registered diffs
  always_comb begin
    add_dout = '0;
    for (int k = 0; k < 8; k++) add_dout = add_dout + add_din[k*DW +: DW];
    diff_c = '0;
    for (int j = 0; j < 4; j++)
      diff_c[j*DW +: DW] = add_din[(2*j+1)*DW +: DW] - add_din[2*j*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) add_dout_vec <= '0;
    else if (add_mode) add_dout_vec <= diff_c;
  end

  // reference model: per-beat signed 16-bit sum, and lane differences
  function automatic logic [15:0] ln(input logic [8*DW-1:0] b, input int k);
    return b[k*DW +: DW];
  endfunction

  function automatic int red_beat(input logic [8*DW-1:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'(ln(b, k));
    s = s & 32'hFFFF;
    if (s >= 32768) s -= 65536;
    return s;
  endfunction

  function automatic logic [63:0] sub_beat(input logic [8*DW-1:0] b);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = ln(b, 2*j+1) - ln(b, 2*j);
    return v;
  endfunction

  function automatic logic [8*DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_cmd(input bit op, input int len,
                         output logic [AW-1:0] rsum,
                         output logic [63:0] rvec0);
    int sent, done_in, acc, cyc;
    bit vv_due, vl_due, fin, first, v, exp_rdy, exp_done;
    logic [63:0] vq[$];
    logic [63:0] ev;
    sent = 0; done_in = -1; acc = 0; cyc = 0;
    vv_due = 0; vl_due = 0; fin = 0; first = 1;
    rsum = '0; rvec0 = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len); in_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: cmd_ready=%b expected 1", cmd_ready);
    end
    @(posedge clk);
    if (len == 0) done_in = 1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 1'($urandom); cmd_len = LW'($urandom);
      cyc++;
      if (done_in > 0) done_in--;
      exp_done = (done_in == 0);
      checks++;
      if (done !== exp_done || sum_valid !== (exp_done && !op) ||
          busy !== 1'b1 || cmd_ready !== 1'b0 ||
          (exp_done && in_ready !== 1'b0)) begin
        errors++;
        $display("FAIL ctl cyc%0d: done=%b sum_valid=%b busy=%b cmd_ready=%b in_ready=%b expected done=%b sum_valid=%b",
                 cyc, done, sum_valid, busy, cmd_ready, in_ready,
                 exp_done, exp_done && !op);
      end
      checks++;
      if (vec_valid !== vv_due || vec_last !== vl_due) begin
        errors++;
        $display("FAIL framing cyc%0d: vec_valid=%b vec_last=%b expected %b %b",
                 cyc, vec_valid, vec_last, vv_due, vl_due);
      end
      if (vv_due) begin
        ev = vq.pop_front();
        checks++;
        if (vec_data !== ev) begin
          errors++;
          $display("FAIL vec_data: got %h expected %h", vec_data, ev);
        end
        if (first) rvec0 = vec_data;
        first = 0;
      end
      if (exp_done) begin
        if (!op) begin
          checks++;
          if (sum_data !== acc[AW-1:0]) begin
            errors++;
            $display("FAIL sum_data: got %h expected %h", sum_data, acc[AW-1:0]);
          end
          rsum = sum_data;
        end
        fin = 1;
      end
      vv_due = 0; vl_due = 0;
      if (!fin) begin
        case (gap_mode)
          0: v = 1;
          1: v = (cyc % 2 == 1);
          default: v = ($urandom_range(99) >= 35);
        endcase
        exp_rdy = (sent < len);
        in_valid = v;
        in_data = rnd_beat();
        if (v && exp_rdy && beat_q.size() > 0) in_data = beat_q.pop_front();
        #1;
        checks++;
        if (in_ready !== exp_rdy || add_mode !== (op && exp_rdy)) begin
          errors++;
          $display("FAIL handshake cyc%0d: in_ready=%b add_mode=%b expected %b %b",
                   cyc, in_ready, add_mode, exp_rdy, op && exp_rdy);
        end
        if (v && exp_rdy) begin
          sent++;
          if (op) begin
            vq.push_back(sub_beat(in_data));
            vv_due = 1;
            vl_due = (sent == len);
          end else begin
            acc += red_beat(in_data);
          end
          if (sent == len) done_in = op ? 2 : 1;
        end
      end
    end
    in_valid = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        vec_valid !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: cmd_ready=%b busy=%b done=%b vec_valid=%b sum_valid=%b expected 1 0 0 0 0",
               cmd_ready, busy, done, vec_valid, sum_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
      cmd_len = LW'($urandom); in_valid = 1'($urandom); in_data = rnd_beat();
      #1;
      checks++;
      if (cmd_ready !== 0 || in_ready !== 0 || add_mode !== 0 ||
          add_din !== '0 || sum_valid !== 0 || sum_data !== '0 ||
          vec_valid !== 0 || vec_data !== '0 || vec_last !== 0 ||
          busy !== 0 || done !== 0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b ir=%b mode=%b din=%h sv=%b sd=%h vv=%b vd=%h vl=%b busy=%b done=%b expected all 0",
                 cmd_ready, in_ready, add_mode, add_din, sum_valid, sum_data,
                 vec_valid, vec_data, vec_last, busy, done);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reduce_wrap();
    logic [AW-1:0] s;
    logic [63:0] v;
    logic [15:0] one, big;
    one = 16'h0001; big = 16'h7FFF;
    beat_q.delete();
    beat_q.push_back({8{one}});
    beat_q.push_back({8{big}});
    gap_mode = 0;
    run_cmd(1'b0, 2, s, v);
    checks++;
    if (s !== '0) begin
      errors++;
      $display("FAIL reduce_wrap: sum_data=%h expected 0", s);
    end
  endtask

  task automatic test_sub_gaps();
    logic [AW-1:0] s;
    logic [63:0] v;
    beat_q.delete();
    beat_q.push_back({16'h0000, 16'h0007, 16'h0003, 16'hFFFE,
                      16'h0001, 16'h0001, 16'h000C, 16'h0005});
    gap_mode = 1;
    run_cmd(1'b1, 3, s, v);
    checks++;
    if (v !== 64'hFFF9_0005_0000_0007) begin
      errors++;
      $display("FAIL sub_gaps_vec0: got %h expected fff9000500000007", v);
    end
  endtask

  task automatic test_sub_edges();
    logic [AW-1:0] s;
    logic [63:0] v;
    beat_q.delete();
    beat_q.push_back({16'h0, 16'h0, 16'h0, 16'h0,
                      16'h0000, 16'h8000, 16'hFFFD, 16'h0000});
    gap_mode = 0;
    run_cmd(1'b1, 1, s, v);
    checks++;
    if (v !== 64'h0000_0000_8000_FFFD) begin
      errors++;
      $display("FAIL sub_edges: got %h expected 000000008000fffd", v);
    end
  endtask

  task automatic test_zero_len();
    logic [AW-1:0] s;
    logic [63:0] v;
    gap_mode = 0;
    run_cmd(1'b0, 0, s, v);
    checks++;
    if (s !== '0) begin
      errors++;
      $display("FAIL zero_len: sum_data=%h expected 0", s);
    end
    run_cmd(1'b1, 0, s, v);
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] s;
    logic [63:0] v;
    logic [15:0] two;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_len = 8'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    in_data = {8{16'h0101}};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_data !== '0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b sum_data=%h sum_valid=%b expected 0 0 0 0",
               busy, done, sum_data, sum_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    two = 16'h0002;
    beat_q.delete();
    beat_q.push_back({8{two}});
    gap_mode = 0;
    run_cmd(1'b0, 1, s, v);
    checks++;
    if (s !== 24'd16) begin
      errors++;
      $display("FAIL reset_mid_next: sum_data=%0d expected 16", s);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] s;
    logic [63:0] v;
    beat_q.delete();
    for (int i = 0; i < 16; i++) begin
      gap_mode = $urandom_range(2);
      run_cmd(1'($urandom), $urandom_range(12, 1), s, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] s;
    logic [63:0] v;
    beat_q.delete();
    gap_mode = 0;
    for (int i = 0; i < 4; i++) run_cmd(1'(i % 2), 5 + i, s, v);
  endtask

  initial begin
    test_reset();
    test_reduce_wrap();
    test_sub_gaps();
    test_sub_edges();
    test_zero_len();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
